// File: rtl/cmd_reply_packer_if.sv
// rtl/cmd_reply_packer_if.sv - reply-word input and RX FIFO output signals of cmd_reply_packer
interface cmd_reply_packer_if;
  logic [31:0] adc_time;
  logic [15:0] rx_databus;
  logic        rx_WR;
  logic        rx_WR_done;
  logic        rx_WR_enabled;
  logic [15:0] out_data;
  logic        out_wr;
  logic        out_have_space;
  logic        overflow;
  logic [15:0] pkt_count;

  modport slave (
    input  adc_time, rx_databus, rx_WR, rx_WR_done, out_have_space,
    output rx_WR_enabled, out_data, out_wr, overflow, pkt_count
  );

  modport master (
    output adc_time, rx_databus, rx_WR, rx_WR_done, out_have_space,
    input  rx_WR_enabled, out_data, out_wr, overflow, pkt_count
  );
endinterface

// File: rtl/cmd_reply_packer.sv
// rtl/cmd_reply_packer.sv - buffers command-reader reply words and frames them as one 512-byte in-band packet
// Optional idle-flush timer enabled by defining CMD_REPLY_TIMEOUT_EN.
module cmd_reply_packer #(
  parameter int         MAX_WORDS      = 252,
  parameter int         PKT_WORDS      = 256,
  parameter logic [4:0] CHANNEL        = 5'h1F,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                 txclk,
  input  logic                 reset,
  cmd_reply_packer_if.slave    bus
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int WW = $clog2(PKT_WORDS);

  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_HDR_LO  = 3'd2;
  localparam logic [2:0] ST_HDR_HI  = 3'd3;
  localparam logic [2:0] ST_TS_LO   = 3'd4;
  localparam logic [2:0] ST_TS_HI   = 3'd5;
  localparam logic [2:0] ST_PAYLOAD = 3'd6;
  localparam logic [2:0] ST_PAD     = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [8:0]    hdr_len_q, hdr_len_d;
  logic [31:0]   ts_q, ts_d;
  logic [15:0]   pkt_q, pkt_d;
  logic          done_q;
  logic          ovf_q, ovf_d;
  logic          en_q, en_d;

  logic [15:0]   payload_mem [0:MAX_WORDS-1];

  logic          collecting;
  logic          wr_ok;
  logic [CW-1:0] cnt_inc;
  logic          done_rise;
  logic          timeout_hit;
  logic          trigger;
  logic          last_word;

  assign collecting = (state_q == ST_COLLECT);
  assign wr_ok      = collecting && bus.rx_WR && (count_q < CW'(MAX_WORDS));
  assign cnt_inc    = count_q + CW'(wr_ok);
  assign done_rise  = bus.rx_WR_done && !done_q;
  assign last_word  = (wcnt_q == WW'(PKT_WORDS - 1));

`ifdef CMD_REPLY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q;
  logic          idling;

  // Idle time only accrues while words are waiting and the reader is silent.
  assign idling      = collecting && (count_q != '0) && !bus.rx_WR;
  assign timeout_hit = idling && (idle_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else if (idling) begin
      idle_q <= idle_q + TW'(1);
    end else begin
      idle_q <= '0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // A word arriving in the trigger cycle is already counted in cnt_inc.
  assign trigger = collecting &&
                   (((done_rise || timeout_hit) && (cnt_inc != '0)) ||
                    (cnt_inc == CW'(MAX_WORDS)));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_d      = rd_q;
    wcnt_d    = wcnt_q;
    hdr_len_d = hdr_len_q;
    ts_d      = ts_q;
    pkt_d     = pkt_q;
    ovf_d     = ovf_q || (bus.rx_WR && !wr_ok);

    case (state_q)
      ST_COLLECT: begin
        count_d = cnt_inc;
        if (trigger) begin
          state_d   = ST_WAIT;
          hdr_len_d = 9'({cnt_inc, 1'b0});
          ts_d      = bus.adc_time;
        end
      end
      ST_WAIT: begin
        if (bus.out_have_space) begin
          state_d = ST_HDR_LO;
          wcnt_d  = '0;
          rd_d    = '0;
        end
      end
      ST_HDR_LO, ST_HDR_HI, ST_TS_LO, ST_TS_HI: begin
        state_d = state_q + 3'd1;
        wcnt_d  = wcnt_q + WW'(1);
      end
      ST_PAYLOAD: begin
        wcnt_d = wcnt_q + WW'(1);
        rd_d   = rd_q + CW'(1);
        if (rd_q == count_q - CW'(1)) begin
          if (last_word) begin
            state_d = ST_COLLECT;
            count_d = '0;
            pkt_d   = pkt_q + 16'd1;
          end else begin
            state_d = ST_PAD;
          end
        end
      end
      default: begin
        wcnt_d = wcnt_q + WW'(1);
        if (last_word) begin
          state_d = ST_COLLECT;
          count_d = '0;
          pkt_d   = pkt_q + 16'd1;
        end
      end
    endcase

    // Room for a full back-to-back word pair, aligned with the count it reflects.
    en_d = (state_d == ST_COLLECT) && (count_d <= CW'(MAX_WORDS - 2));
  end

  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_COLLECT;
      count_q   <= '0;
      rd_q      <= '0;
      wcnt_q    <= '0;
      hdr_len_q <= '0;
      ts_q      <= '0;
      pkt_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_q      <= rd_d;
      wcnt_q    <= wcnt_d;
      hdr_len_q <= hdr_len_d;
      ts_q      <= ts_d;
      pkt_q     <= pkt_d;
      done_q    <= bus.rx_WR_done;
      ovf_q     <= ovf_d;
      en_q      <= en_d;
    end
  end

  always_ff @(posedge txclk) begin
    if (wr_ok) begin
      payload_mem[count_q] <= bus.rx_databus;
    end
  end

  // Outputs decode straight from registered state so reset silences out_wr immediately.
  always_comb begin
    bus.out_data = 16'h0000;
    case (state_q)
      ST_HDR_LO:  bus.out_data = {7'b0, hdr_len_q};
      ST_HDR_HI:  bus.out_data = {3'b0, 1'b1, 1'b1, 6'b0, CHANNEL};
      ST_TS_LO:   bus.out_data = ts_q[15:0];
      ST_TS_HI:   bus.out_data = ts_q[31:16];
      ST_PAYLOAD: bus.out_data = payload_mem[rd_q];
      default:    bus.out_data = 16'h0000;
    endcase
  end

  assign bus.out_wr        = (state_q >= ST_HDR_LO);
  assign bus.rx_WR_enabled = en_q;
  assign bus.overflow      = ovf_q;
  assign bus.pkt_count     = pkt_q;

endmodule

// File: tb/tb_cmd_reply_packer.sv
// tb/tb_cmd_reply_packer.sv - randomized self-checking bench for cmd_reply_packer against a packet-level model
module tb_cmd_reply_packer;

  logic txclk = 1'b0;
  logic reset = 1'b1;
  always #5 txclk = ~txclk;

  cmd_reply_packer_if bus();

  cmd_reply_packer #(.TIMEOUT_CYCLES(16)) dut (
    .txclk (txclk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int exp_pkts = 0;
  logic [15:0] reply_q[$];
  logic [15:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference packet: header, timestamp, reply words, zero pad to 256 words.
  task automatic build_pkt(input logic [31:0] ts);
    exp_q.delete();
    exp_q.push_back(16'(2 * reply_q.size()));
    exp_q.push_back(16'h1800 + 16'h001F);
    exp_q.push_back(ts[15:0]);
    exp_q.push_back(ts[31:16]);
    foreach (reply_q[i]) exp_q.push_back(reply_q[i]);
    while (exp_q.size() < 256) exp_q.push_back(16'h0000);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge txclk);
      #1;
    end
  endtask

  task automatic write_word(input logic [15:0] w);
    bus.rx_databus = w;
    bus.rx_WR      = 1'b1;
    @(posedge txclk);
    #1;
    bus.rx_WR      = 1'b0;
  endtask

  task automatic fill(input int n, input int max_gap);
    logic [15:0] w;
    reply_q.delete();
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      reply_q.push_back(w);
      write_word(w);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic recv(input string tag, input int delay, input bit chk_lat);
    int first;
    int bad;
    int k;
    logic [15:0] got [4];
    first = -1;
    bad = 0;
    k = 0;
    while (first < 0 && k < 3000) begin
      @(negedge txclk);
      if (bus.out_wr) begin
        first = k;
      end else begin
        if (chk_lat && k == 1) check_val({tag, "_wait_en"}, 32'(bus.rx_WR_enabled), 0);
        if (k == delay) bus.out_have_space = 1'b1;
        k++;
      end
    end
    check_val({tag, "_start"}, 32'(first >= 0), 1);
    if (first >= 0) begin
      if (chk_lat) check_val({tag, "_lat"}, first, (delay <= 1) ? 2 : delay + 1);
      for (int i = 0; i < 256; i++) begin
        if (i > 0) @(negedge txclk);
        if (i < 4) got[i] = bus.out_data;
        if (bus.out_wr !== 1'b1 || bus.out_data !== exp_q[i]) bad++;
      end
      check_val({tag, "_hdr_lo"}, got[0], exp_q[0]);
      check_val({tag, "_hdr_hi"}, got[1], exp_q[1]);
      check_val({tag, "_ts_lo"}, got[2], exp_q[2]);
      check_val({tag, "_ts_hi"}, got[3], exp_q[3]);
      check_val({tag, "_bad_words"}, bad, 0);
      @(negedge txclk);
      check_val({tag, "_end_wr"}, 32'(bus.out_wr), 0);
      check_val({tag, "_end_en"}, 32'(bus.rx_WR_enabled), 1);
      check_val({tag, "_pkt_count"}, bus.pkt_count, exp_pkts);
    end
    @(posedge txclk);
    #1;
  endtask

  task automatic count_wr(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(negedge txclk);
      if (bus.out_wr) seen++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int k;
    int d;
    int dsel [4];
    logic [31:0] ts;

    dsel[0] = 0; dsel[1] = 0; dsel[2] = 2; dsel[3] = 7;
    bus.adc_time       = 32'h0;
    bus.rx_databus     = 16'h0;
    bus.rx_WR          = 1'b0;
    bus.rx_WR_done     = 1'b0;
    bus.out_have_space = 1'b1;

    repeat (3) @(posedge txclk);
    @(negedge txclk);
    check_val("rst_out_wr", 32'(bus.out_wr), 0);
    check_val("rst_en", 32'(bus.rx_WR_enabled), 0);
    check_val("rst_ovf", 32'(bus.overflow), 0);
    check_val("rst_pkt", bus.pkt_count, 0);
    reset = 1'b0;
    @(negedge txclk);
    check_val("rel_en", 32'(bus.rx_WR_enabled), 1);
    @(posedge txclk);
    #1;

    // Ping reply
    bus.adc_time = 32'h0000_1000;
    reply_q.delete();
    reply_q.push_back(16'h1234);
    reply_q.push_back(16'h0102);
    write_word(16'h1234);
    write_word(16'h0102);
    build_pkt(32'h0000_1000);
    bus.rx_WR_done = 1'b1;
    exp_pkts++;
    recv("ping", 0, 1);

    // FIFO space withheld for 50 cycles
    bus.rx_WR_done = 1'b0;
    bus.out_have_space = 1'b0;
    fill(3, 0);
    bus.adc_time = 32'hCAFE_0001;
    build_pkt(32'hCAFE_0001);
    bus.rx_WR_done = 1'b1;
    exp_pkts++;
    recv("space50", 50, 1);

    // Randomized replies
    for (int it = 0; it < 8; it++) begin
      bus.rx_WR_done = 1'b0;
      d = dsel[$urandom_range(0, 3)];
      bus.out_have_space = (d == 0);
      fill($urandom_range(1, 60), 2);
      ts = $urandom;
      bus.adc_time = ts;
      build_pkt(ts);
      bus.rx_WR_done = 1'b1;
      exp_pkts++;
      recv($sformatf("rnd%0d", it), d, 1);
    end

    // Done edge with empty buffer
    bus.rx_WR_done = 1'b0;
    idle(2);
    bus.rx_WR_done = 1'b1;
    count_wr(20, seen);
    check_val("empty_done_wr", seen, 0);
    @(posedge txclk);
    #1;

    // Full buffer auto-flush plus a dropped 253rd word
    bus.rx_WR_done = 1'b0;
    bus.out_have_space = 1'b0;
    ts = $urandom;
    bus.adc_time = ts;
    fill(250, 0);
    @(negedge txclk);
    check_val("full_en250", 32'(bus.rx_WR_enabled), 1);
    @(posedge txclk);
    #1;
    reply_q.push_back(16'hA251);
    write_word(16'hA251);
    @(negedge txclk);
    check_val("full_en251", 32'(bus.rx_WR_enabled), 0);
    @(posedge txclk);
    #1;
    reply_q.push_back(16'hA252);
    write_word(16'hA252);
    build_pkt(ts);
    write_word(16'hDEAD);
    @(negedge txclk);
    check_val("full_ovf", 32'(bus.overflow), 1);
    @(posedge txclk);
    #1;
    exp_pkts++;
    recv("full", 4, 0);

    // Overflow stays set across a normal packet
    fill(5, 1);
    ts = $urandom;
    bus.adc_time = ts;
    build_pkt(ts);
    bus.rx_WR_done = 1'b1;
    exp_pkts++;
    recv("post_ovf", 0, 1);
    check_val("ovf_sticky", 32'(bus.overflow), 1);

    // Reset during PAYLOAD
    bus.rx_WR_done = 1'b0;
    fill(10, 0);
    bus.rx_WR_done = 1'b1;
    seen = 0;
    k = 0;
    while (seen == 0 && k < 50) begin
      @(negedge txclk);
      if (bus.out_wr) seen = 1;
      k++;
    end
    check_val("abort_start", seen, 1);
    repeat (6) @(negedge txclk);
    reset = 1'b1;
    #1;
    check_val("abort_wr", 32'(bus.out_wr), 0);
    exp_pkts = 0;
    bus.rx_WR_done = 1'b0;
    repeat (3) @(negedge txclk);
    check_val("abort_ovf", 32'(bus.overflow), 0);
    check_val("abort_pkt", bus.pkt_count, 0);
    reset = 1'b0;
    count_wr(20, seen);
    check_val("abort_quiet", seen, 0);
    @(posedge txclk);
    #1;
    fill(7, 1);
    ts = $urandom;
    bus.adc_time = ts;
    build_pkt(ts);
    bus.rx_WR_done = 1'b1;
    exp_pkts++;
    recv("after_abort", 0, 1);

    // Single word with no done: idle-flush only when the timer is built in
    bus.rx_WR_done = 1'b0;
    idle(1);
    fill(1, 0);
    ts = $urandom;
    bus.adc_time = ts;
    build_pkt(ts);
    exp_pkts++;
`ifdef CMD_REPLY_TIMEOUT_EN
    recv("timeout", 0, 0);
`else
    count_wr(40, seen);
    check_val("no_timeout_wr", seen, 0);
    @(posedge txclk);
    #1;
    bus.rx_WR_done = 1'b1;
    recv("late_done", 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
